rpsc_interlock_seq: RTL
=======================

RPSC_INTERLOCK_SEQ -- requirements
Module: rpsc_interlock_seq

Interface
REQ-001 Parameter N_STATUS, default 7: number of interlock status inputs.
REQ-002 Parameter ON_DELAY, default 3125000: arming delay in clk cycles (4 s at 1.28 us); SHALL be >= 2.
REQ-003 Parameter SUPV_DELAY, default 46875000: supervision delay in clk cycles (60 s); SHALL be >= 2.
REQ-004 Parameter LATCH_EN, default 1: 1 = latch status faults until acknowledged; 0 = track status.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 status  in  N_STATUS  interlock faults, active-high (card pos, air, water, DC PS, U low, I high, ...).
REQ-008 status_mask  in  N_STATUS  1 = bit ignored for new faults.
REQ-009 not_g1_ok, fan_on  in  1 each  external inhibits, active-high.
REQ-010 ps_act  in  1  CA power-supply activate request.
REQ-011 fault_ack  in  1  operator acknowledge, level.
REQ-012 i_high, u_low  in  1 each  CA current-high / voltage-low monitors.
REQ-013 fault_latched  out  N_STATUS  registered fault bits.
REQ-014 not_alarm, permit, ca_on_perm_n, on_delay, ca_delay, not_ca_ok, i_high_n, u_low_n  out  1 each.
REQ-015 state  out  3  FSM state code: IDLE=0, ARMING=1, RUN=2, OK=3, FAULT=4.

Function
REQ-016 Fault set per bit i SHALL be status[i] & ~status_mask[i], registered into fault_latched[i].
REQ-017 LATCH_EN=1: a set bit SHALL hold until an edge with fault_ack=1 and its set term =0; set wins over ack on the same edge.
REQ-018 LATCH_EN=0: fault_latched SHALL equal the set term delayed one cycle; fault_ack ignored.
REQ-019 Asserting a mask bit SHALL NOT clear an already latched bit.
REQ-020 not_alarm = ~|fault_latched; permit = not_alarm & ~not_g1_ok & ~fan_on; ca_on_perm_n = ~permit (combinational).
REQ-021 enable = permit & ps_act; one counter of width $clog2(max(ON_DELAY,SUPV_DELAY)) shared by ARMING and RUN.
REQ-022 IDLE: counter 0; enable=1 -> ARMING with counter 0.
REQ-023 ARMING: counter +1 per cycle; counter==ON_DELAY-1 and enable -> RUN, counter 0.
REQ-024 RUN: counter +1 per cycle; counter==SUPV_DELAY-1 and enable -> OK, counter 0.
REQ-025 OK: hold while enable=1.
REQ-026 ARMING/RUN/OK with enable=0: not_alarm=0 -> FAULT, else -> IDLE; counter 0; takes priority over terminal count.
REQ-027 IDLE with not_alarm=0 -> FAULT.
REQ-028 FAULT: exit to IDLE only when not_alarm=1 and ps_act=0 on the same edge; ps_act held high keeps FAULT after ack.
REQ-029 on_delay = state in {RUN,OK}; ca_delay = (state==OK); not_ca_ok = ~(state==OK).
REQ-030 i_high_n = ~(on_delay & i_high); u_low_n = ~(on_delay & u_low) (combinational, active-low).
REQ-031 Latency: on_delay rises ON_DELAY cycles after ARMING entry; ca_delay rises SUPV_DELAY cycles after RUN entry.
REQ-032 Latency: unmasked status rise -> not_alarm low after 1 edge -> state FAULT after 2nd edge.
REQ-033 Undefined state codes SHALL recover to IDLE on the next edge.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, counter=0, fault_latched=0, independent of clk.
REQ-035 During reset: not_alarm=1, on_delay=0, ca_delay=0, not_ca_ok=1, i_high_n=1, u_low_n=1; permit/ca_on_perm_n follow inputs.
REQ-036 Reset asserted mid-ARMING/RUN/OK SHALL abort the sequence; a new run restarts the full ON_DELAY.

Verification (ON_DELAY=15, SUPV_DELAY=20, N_STATUS=7, LATCH_EN=1)
REQ-037 status=0, inhibits=0, ps_act=1 from reset release -> ARMING next edge; on_delay=1 after 15 cycles; ca_delay=1, not_ca_ok=0 after 20 more.
REQ-038 In OK, pulse status[3] one cycle -> not_alarm=0 next edge, state=FAULT one edge later; fault_latched=7'b0001000 held; ack with ps_act=1 -> FAULT stays; drop ps_act -> IDLE.
REQ-039 status_mask[0]=1, status[0]=1 -> no latch, sequence completes; fault_ack with status[2] still high -> bit 2 stays set.
REQ-040 ps_act drop in ARMING at count 10 -> IDLE, counter 0; reassert -> on_delay only after a full 15 cycles.
REQ-041 i_high=1 in ARMING -> i_high_n=1; in RUN -> i_high_n=0; fan_on=1 in RUN -> ca_on_perm_n=1, state IDLE next edge.
REQ-042 reset low mid-RUN between clk edges -> outputs at reset values immediately; LATCH_EN=0 run: fault clears one cycle after status drops without ack.

Source files
------------

// File: rtl/rpsc_interlock_seq.sv
// -----------------------------------------------------------------------------
// rpsc_interlock_seq
//
// Power-supply interlock sequencer. Unmasked status faults are registered (and
// optionally latched until acknowledged). When no fault is present and no
// external inhibit is active, a ps_act request starts the sequence:
//   IDLE -> ARMING (ON_DELAY cycles) -> RUN (SUPV_DELAY cycles) -> OK.
// Losing the enable at any point aborts the sequence. It returns to IDLE if no
// fault is present, or goes to FAULT if one is. FAULT is left only when the
// faults are cleared and ps_act has been dropped.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   status        in   [N_STATUS] interlock fault inputs, active-high
//   status_mask   in   [N_STATUS] 1 = bit ignored for new faults
//   not_g1_ok     in   external inhibit, active-high
//   fan_on        in   external inhibit, active-high
//   ps_act        in   power-supply activate request
//   fault_ack     in   operator acknowledge (level)
//   i_high        in   current-high monitor
//   u_low         in   voltage-low monitor
//   fault_latched out  [N_STATUS] registered fault bits
//   not_alarm     out  1 = no fault registered
//   permit        out  no fault and no inhibit
//   ca_on_perm_n  out  ~permit
//   on_delay      out  state is RUN or OK
//   ca_delay      out  state is OK
//   not_ca_ok     out  state is not OK
//   i_high_n      out  ~(on_delay & i_high)
//   u_low_n       out  ~(on_delay & u_low)
//   state         out  [3] IDLE=0 ARMING=1 RUN=2 OK=3 FAULT=4
// -----------------------------------------------------------------------------
module rpsc_interlock_seq #(
    parameter int N_STATUS   = 7,
    parameter int ON_DELAY   = 3125000,
    parameter int SUPV_DELAY = 46875000,
    parameter int LATCH_EN   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_STATUS-1:0] status,
    input  logic [N_STATUS-1:0] status_mask,
    input  logic                not_g1_ok,
    input  logic                fan_on,
    input  logic                ps_act,
    input  logic                fault_ack,
    input  logic                i_high,
    input  logic                u_low,
    output logic [N_STATUS-1:0] fault_latched,
    output logic                not_alarm,
    output logic                permit,
    output logic                ca_on_perm_n,
    output logic                on_delay,
    output logic                ca_delay,
    output logic                not_ca_ok,
    output logic                i_high_n,
    output logic                u_low_n,
    output logic [2:0]          state
);

    localparam int MAX_DELAY = (ON_DELAY > SUPV_DELAY) ? ON_DELAY : SUPV_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY);

    localparam logic [CNT_W-1:0] ON_TC   = CNT_W'(ON_DELAY - 1);
    localparam logic [CNT_W-1:0] SUPV_TC = CNT_W'(SUPV_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMING = 3'd1,
        S_RUN    = 3'd2,
        S_OK     = 3'd3,
        S_FAULT  = 3'd4
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [N_STATUS-1:0] fault_q;
    logic [N_STATUS-1:0] fault_d;
    logic [N_STATUS-1:0] set_s;
    logic                enable_s;
    logic                abort_s;
    state_e              abort_state_s;

    // Status/permit decode and fault register next value.
    always_comb begin
        set_s = status & ~status_mask;
        if (LATCH_EN != 0) begin
            // Set wins over ack; a bit only clears when its set term is low.
            // Masking a bit removes only its set term, so latched bits stay.
            fault_d = set_s | (fault_q & ~{N_STATUS{fault_ack}});
        end else begin
            fault_d = set_s;
        end
        not_alarm     = ~(|fault_q);
        permit        = not_alarm & ~not_g1_ok & ~fan_on;
        ca_on_perm_n  = ~permit;
        enable_s      = permit & ps_act;
        // Losing enable mid-sequence: faults send us to FAULT, otherwise IDLE.
        abort_s       = ~enable_s;
        abort_state_s = not_alarm ? S_IDLE : S_FAULT;
    end

    // Sequencer next-state and shared delay counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        case (state_q)
            S_IDLE: begin
                if (!not_alarm) begin
                    state_d = S_FAULT;
                end else if (enable_s) begin
                    state_d = S_ARMING;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARMING: begin
                if (abort_s) begin
                    state_d = abort_state_s;
                end else if (cnt_q == ON_TC) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                if (abort_s) begin
                    state_d = abort_state_s;
                end else if (cnt_q == SUPV_TC) begin
                    state_d = S_OK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_OK: begin
                if (abort_s) begin
                    state_d = abort_state_s;
                end else begin
                    state_d = S_OK;
                end
            end
            S_FAULT: begin
                if (not_alarm && !ps_act) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and fault registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // State-derived outputs.
    always_comb begin
        fault_latched = fault_q;
        state         = state_q;
        on_delay      = (state_q == S_RUN) || (state_q == S_OK);
        ca_delay      = (state_q == S_OK);
        not_ca_ok     = ~(state_q == S_OK);
        i_high_n      = ~(on_delay & i_high);
        u_low_n       = ~(on_delay & u_low);
    end

endmodule
